// File: rtl/alu_pkg.sv
// Shared definitions for the ALU built-in self-test: opcode encodings,
// datapath widths and the sweep controller state enumeration.
package alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned IDX_W  = OP_W + 2 * DATA_W;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD = 3'd4;
  localparam logic [OP_W-1:0] OP_SUB = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_model.sv
// Combinational golden model of the ALU under test: S, A, B -> expected F.
module alu_model
  import alu_pkg::*;
(
  input  logic [2:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] F
);

  // Reference result for every opcode; arithmetic wraps modulo 16.
  always_comb begin
    F = '0;
    case (S)
      OP_AND:  F = A & B;
      OP_OR:   F = A | B;
      OP_XOR:  F = A ^ B;
      OP_NOT:  F = ~A;
      OP_ADD:  F = A + B;
      OP_SUB:  F = A - B;
      OP_SHL:  F = {A[2:0], 1'b0};
      OP_SHR:  F = {1'b0, A[3:1]};
      default: F = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// Exhaustive self-test sequencer for a 4-bit, 8-opcode ALU. Drives all
// 2048 {S,A,B} vectors, waits SETTLE_CYC cycles per vector, compares F
// against alu_model and reports a saturating error count plus the first
// failing vector.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  F,
  output logic [2:0]  S,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [14:0] first_fail
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [3:0]       settle_cnt, settle_nxt;
  logic [2:0]       s_nxt;
  logic [3:0]       a_nxt, b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [7:0]       err_nxt;
  logic [14:0]      ff_nxt;
  logic [3:0]       f_exp;

  alu_model u_model (
    .S (S),
    .A (A),
    .B (B),
    .F (f_exp)
  );

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      S          <= '0;
      A          <= '0;
      B          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_nxt;
      S          <= s_nxt;
      A          <= a_nxt;
      B          <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      first_fail <= ff_nxt;
    end
  end

  // Sweep sequencing: next state and next values of all registered outputs.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    settle_nxt = settle_cnt;
    s_nxt      = S;
    a_nxt      = A;
    b_nxt      = B;
    busy_nxt   = busy;
    done_nxt   = done;
    err_nxt    = err_count;
    ff_nxt     = first_fail;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          err_nxt   = '0;
          ff_nxt    = '0;
          idx_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        {s_nxt, a_nxt, b_nxt} = idx;
        if (SETTLE_CYC > 1) begin
          state_nxt  = ST_WAIT;
          settle_nxt = SETTLE_LOAD;
        end else begin
          state_nxt = ST_CHECK;
        end
      end
      ST_WAIT: begin
        // Loaded with SETTLE_CYC-1; leave on the cycle the count reads 1.
        if (settle_cnt <= 4'd1) begin
          settle_nxt = '0;
          state_nxt  = ST_CHECK;
        end else begin
          settle_nxt = settle_cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (F != f_exp) begin
          if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
          if (err_count == 8'd0) ff_nxt = {S, A, B, F};
        end
        if (idx == IDX_LAST) begin
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    pass_nxt = done_nxt && (err_nxt == 8'd0);
  end

endmodule
